// File: rtl/bl_pkg.sv
// ==== bl_pkg : shared constants, types and helpers for the backlight PWM fader | rev 1.0 ====
`default_nettype none

package bl_pkg;

   localparam int MAX_LEVEL    = 100;
   localparam int DEF_PERIOD   = 1000;
   localparam int DEF_FADE_DIV = 4;
   localparam int LEVEL_W      = 7;

   typedef logic [LEVEL_W-1:0] level_t;

   typedef enum logic [1:0] {
      FADE_HOLD = 2'd0,
      FADE_UP   = 2'd1,
      FADE_DOWN = 2'd2
   } fade_dir_e;

   // Requested levels above full scale saturate rather than wrap.
   function automatic level_t clamp_level(input logic [7:0] lvl);
      if (lvl > 8'(MAX_LEVEL)) begin
         return level_t'(MAX_LEVEL);
      end
      return lvl[LEVEL_W-1:0];
   endfunction

   function automatic fade_dir_e fade_dir(input level_t cur, input level_t tgt);
      if (cur < tgt) begin
         return FADE_UP;
      end
      if (cur > tgt) begin
         return FADE_DOWN;
      end
      return FADE_HOLD;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bl_fade_channel.sv
// ==== bl_fade_channel : per-channel target/current level, threshold latch and PWM compare | rev 1.0 ====
`default_nettype none

module bl_fade_channel
   import bl_pkg::*;
#(
   parameter int PERIOD     = DEF_PERIOD,
   parameter int CW         = $clog2(DEF_PERIOD + 1),
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr,
   input  level_t        i_wr_level,
   input  logic          i_fade_en,
   input  logic          i_tick,
   input  logic          i_fade_step,
   input  logic [CW-1:0] i_cnt,
   output logic          o_pwm,
   output logic          o_settled
);

   localparam logic [CW-1:0] c_STEP = CW'(PERIOD / MAX_LEVEL);

   level_t        r_target;
   level_t        r_cur;
   logic [CW-1:0] r_thr;
   logic          r_pwm;
   logic          r_settled;

   level_t        w_cur_nxt;
   logic [CW-1:0] w_thr_nxt;
   fade_dir_e     w_dir;

   always_comb begin
      w_dir     = fade_dir(r_cur, r_target);
      w_cur_nxt = r_cur;
      if (!i_fade_en) begin
         w_cur_nxt = r_target;
      end else if (i_fade_step) begin
         case (w_dir)
            FADE_UP:   w_cur_nxt = r_cur + level_t'(1);
            FADE_DOWN: w_cur_nxt = r_cur - level_t'(1);
            default:   w_cur_nxt = r_cur;
         endcase
      end
      // Largest product is MAX_LEVEL * c_STEP == PERIOD, which fits in CW bits.
      w_thr_nxt = CW'(w_cur_nxt) * c_STEP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_target  <= '0;
         r_cur     <= '0;
         r_thr     <= '0;
         r_pwm     <= ACTIVE_LOW;
         r_settled <= 1'b1;
      end else begin
         if (i_wr) begin
            r_target <= i_wr_level;
         end
         // Level and threshold move together only at the period boundary.
         if (i_tick) begin
            r_cur <= w_cur_nxt;
            r_thr <= w_thr_nxt;
         end
         r_pwm     <= (i_cnt < r_thr) ^ ACTIVE_LOW;
         r_settled <= (r_cur == r_target);
      end
   end

   assign o_pwm     = r_pwm;
   assign o_settled = r_settled;

endmodule

`default_nettype wire

// File: rtl/bl_pwm_fader.sv
// ==== bl_pwm_fader : multi-channel backlight PWM with jump or linear fade to target | rev 1.0 ====
`default_nettype none

module bl_pwm_fader
   import bl_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int PERIOD     = DEF_PERIOD,
   parameter int FADE_DIV   = DEF_FADE_DIV,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_valid,
   input  logic [2:0]        wr_ch,
   input  logic [7:0]        wr_level,
   input  logic              fade_en,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [NUM_CH-1:0] settled,
   output logic              period_tick
);

   localparam int            CW          = $clog2(PERIOD + 1);
   localparam logic [CW-1:0] c_CNT_LAST  = CW'(PERIOD - 1);
   localparam logic [7:0]    c_FDIV_LAST = 8'(FADE_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [7:0]    r_fdiv;

   logic          w_tick;
   logic          w_fade_step;
   level_t        w_wr_level;

   assign w_tick      = (r_cnt == c_CNT_LAST);
   assign w_fade_step = w_tick && (r_fdiv == c_FDIV_LAST);
   assign w_wr_level  = clamp_level(wr_level);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Counts period ticks; every FADE_DIV-th tick lets all channels step once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fdiv <= '0;
      end else if (w_tick) begin
         if (r_fdiv == c_FDIV_LAST) begin
            r_fdiv <= '0;
         end else begin
            r_fdiv <= r_fdiv + 8'd1;
         end
      end
   end

   assign period_tick = w_tick;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic w_wr_sel;

      assign w_wr_sel = wr_valid && (wr_ch == 3'(gi));

      bl_fade_channel #(
         .PERIOD     (PERIOD),
         .CW         (CW),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk         (clk),
         .rst_n       (reset_n),
         .i_wr        (w_wr_sel),
         .i_wr_level  (w_wr_level),
         .i_fade_en   (fade_en),
         .i_tick      (w_tick),
         .i_fade_step (w_fade_step),
         .i_cnt       (r_cnt),
         .o_pwm       (pwm_out[gi]),
         .o_settled   (settled[gi])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_bl_pwm_fader.sv
// ==== tb_bl_pwm_fader : directed self-checking bench for bl_pwm_fader | rev 1.0 ====
`default_nettype none

module tb_bl_pwm_fader;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_valid;
   logic [2:0] wr_ch;
   logic [7:0] wr_level;
   logic       fade_en;
   logic [3:0] pwm_out;
   logic [3:0] settled;
   logic       period_tick;
   logic [3:0] pwm_al;
   logic [3:0] settled_al;
   logic       tick_al;

   int n_cmp  = 0;
   int n_err  = 0;
   int cyc    = 0;
   int hi_cnt [4];
   int al_bad = 0;
   int tick_bad = 0;
   int rise1  = -2;

   always #5 clk = ~clk;

   bl_pwm_fader #(.NUM_CH(4), .PERIOD(1000), .FADE_DIV(4), .ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ch(wr_ch),
      .wr_level(wr_level), .fade_en(fade_en), .pwm_out(pwm_out),
      .settled(settled), .period_tick(period_tick)
   );

   bl_pwm_fader #(.NUM_CH(4), .PERIOD(1000), .FADE_DIV(4), .ACTIVE_LOW(1'b1)) u_al (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ch(wr_ch),
      .wr_level(wr_level), .fade_en(fade_en), .pwm_out(pwm_al),
      .settled(settled_al), .period_tick(tick_al)
   );

   task automatic clear_tally();
      for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
   endtask

   // One cycle; samples at the falling edge, cyc = rising edges since release.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (period_tick !== ((cyc % 1000) == 999)) tick_bad++;
      if (pwm_al !== ~pwm_out || settled_al !== settled || tick_al !== period_tick) al_bad++;
      for (int c = 0; c < 4; c++) if (pwm_out[c] === 1'b1) hi_cnt[c]++;
      if (rise1 == -1 && settled[1] === 1'b1) rise1 = cyc;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic do_reset();
      wr_valid = 1'b0; wr_ch = 3'd0; wr_level = 8'd0; fade_en = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      cyc = 0; al_bad = 0; tick_bad = 0; rise1 = -2;
      clear_tally();
   endtask

   task automatic write(input int ch, input int lvl, input bit fade);
      wr_valid = 1'b1; wr_ch = 3'(ch); wr_level = 8'(lvl); fade_en = fade;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      wr_valid = 1'b1; wr_ch = 3'd0; wr_level = 8'd100; fade_en = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (pwm_out !== 4'h0) begin n_err++; $display("FAIL rst_pwm: got %h want 0", pwm_out); end
      n_cmp++; if (pwm_al !== 4'hF) begin n_err++; $display("FAIL rst_pwm_al: got %h want f", pwm_al); end
      n_cmp++; if (settled !== 4'hF) begin n_err++; $display("FAIL rst_settled: got %h want f", settled); end
      n_cmp++; if (period_tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b want 0", period_tick); end
      wr_valid = 1'b0;
      reset_n = 1'b1;
      cyc = 0; al_bad = 0; tick_bad = 0;
      clear_tally();
      run_to(999);
      n_cmp++; if (period_tick !== 1'b1) begin n_err++; $display("FAIL rst_first_tick: got %b want 1", period_tick); end
      run_to(1999);
      n_cmp++; if (hi_cnt[0] !== 0) begin n_err++; $display("FAIL rst_write_ignored: got %0d want 0", hi_cnt[0]); end
      n_cmp++; if (settled !== 4'hF) begin n_err++; $display("FAIL rst_settled_after: got %h want f", settled); end
      n_cmp++; if (tick_bad !== 0) begin n_err++; $display("FAIL rst_tick_timing: got %0d want 0", tick_bad); end
   endtask

   task automatic test_jump();
      do_reset();
      write(0, 50, 1'b0);
      step();
      n_cmp++; if (settled[0] !== 1'b0) begin n_err++; $display("FAIL jump_unsettled: got %b want 0", settled[0]); end
      run_to(999);
      n_cmp++; if (hi_cnt[0] !== 0) begin n_err++; $display("FAIL jump_before_tick: got %0d want 0", hi_cnt[0]); end
      for (int p = 1; p <= 2; p++) begin
         clear_tally();
         run_to(1000 * p + 999);
         n_cmp++; if (hi_cnt[0] !== 500) begin n_err++; $display("FAIL jump_duty p%0d: got %0d want 500", p, hi_cnt[0]); end
      end
      n_cmp++; if (settled !== 4'hF) begin n_err++; $display("FAIL jump_settled: got %h want f", settled); end
      n_cmp++; if (al_bad !== 0 || tick_bad !== 0) begin n_err++; $display("FAIL jump_al_tick: got %0d/%0d want 0/0", al_bad, tick_bad); end
   endtask

   task automatic test_fade();
      do_reset();
      write(1, 10, 1'b1);
      step();
      n_cmp++; if (settled[1] !== 1'b0) begin n_err++; $display("FAIL fade_unsettled: got %b want 0", settled[1]); end
      rise1 = -1;
      for (int p = 0; p < 42; p++) begin
         int exp_hi;
         exp_hi = 10 * (((p / 4) > 10) ? 10 : (p / 4));
         clear_tally();
         run_to(1000 * p + 999);
         n_cmp++; if (hi_cnt[1] !== exp_hi) begin n_err++; $display("FAIL fade_duty p%0d: got %0d want %0d", p, hi_cnt[1], exp_hi); end
      end
      n_cmp++; if (rise1 !== 40001) begin n_err++; $display("FAIL fade_settle_cycle: got %0d want 40001", rise1); end
      n_cmp++; if (al_bad !== 0 || tick_bad !== 0) begin n_err++; $display("FAIL fade_al_tick: got %0d/%0d want 0/0", al_bad, tick_bad); end
   endtask

   task automatic test_clamp();
      do_reset();
      write(2, 200, 1'b0);
      write(0, 100, 1'b0);
      run_to(999);
      clear_tally();
      run_to(1999);
      n_cmp++; if (hi_cnt[2] !== 999) begin n_err++; $display("FAIL clamp_first_period: got %0d want 999", hi_cnt[2]); end
      clear_tally();
      run_to(2999);
      n_cmp++; if (hi_cnt[2] !== 1000) begin n_err++; $display("FAIL clamp_full: got %0d want 1000", hi_cnt[2]); end
      n_cmp++; if (hi_cnt[0] !== 1000) begin n_err++; $display("FAIL level100_full: got %0d want 1000", hi_cnt[0]); end
      n_cmp++; if (hi_cnt[1] !== 0) begin n_err++; $display("FAIL level0_low: got %0d want 0", hi_cnt[1]); end
      n_cmp++; if (al_bad !== 0) begin n_err++; $display("FAIL clamp_al: got %0d want 0", al_bad); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      write(3, 10, 1'b0);
      run_to(999);
      clear_tally();
      run_to(1999);
      n_cmp++; if (hi_cnt[3] !== 100) begin n_err++; $display("FAIL tw_initial: got %0d want 100", hi_cnt[3]); end
      clear_tally();
      write(3, 30, 1'b0);
      run_to(2499);
      write(7, 77, 1'b0);
      run_to(2999);
      n_cmp++; if (hi_cnt[3] !== 100) begin n_err++; $display("FAIL tw_same_period: got %0d want 100", hi_cnt[3]); end
      clear_tally();
      run_to(3999);
      n_cmp++; if (hi_cnt[3] !== 300) begin n_err++; $display("FAIL tw_next_period: got %0d want 300", hi_cnt[3]); end
      n_cmp++; if (hi_cnt[0] + hi_cnt[1] + hi_cnt[2] !== 0) begin n_err++; $display("FAIL ch7_ignored: got %0d want 0", hi_cnt[0] + hi_cnt[1] + hi_cnt[2]); end
      n_cmp++; if (settled !== 4'hF) begin n_err++; $display("FAIL tw_settled: got %h want f", settled); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      write(0, 100, 1'b0);
      run_to(1499);
      write(1, 10, 1'b1);
      run_to(4499);
      n_cmp++; if (pwm_out[0] !== 1'b1 || settled !== 4'b1101) begin n_err++; $display("FAIL mid_pre: got pwm %h settled %h want pwm0=1 settled d", pwm_out, settled); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (pwm_out !== 4'h0 || pwm_al !== 4'hF) begin n_err++; $display("FAIL mid_pwm_async: got %h/%h want 0/f", pwm_out, pwm_al); end
      n_cmp++; if (settled !== 4'hF) begin n_err++; $display("FAIL mid_settled: got %h want f", settled); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      fade_en = 1'b0;
      cyc = 0; al_bad = 0; tick_bad = 0;
      clear_tally();
      run_to(1999);
      n_cmp++; if (tick_bad !== 0) begin n_err++; $display("FAIL mid_restart_cnt: got %0d want 0", tick_bad); end
      n_cmp++; if (hi_cnt[0] + hi_cnt[1] !== 0) begin n_err++; $display("FAIL mid_state_cleared: got %0d want 0", hi_cnt[0] + hi_cnt[1]); end
      n_cmp++; if (settled !== 4'hF) begin n_err++; $display("FAIL mid_settled_after: got %h want f", settled); end
   endtask

   initial begin
      reset_n = 1'b0; wr_valid = 1'b0; wr_ch = 3'd0; wr_level = 8'd0; fade_en = 1'b0;
      test_reset();
      test_jump();
      test_fade();
      test_clamp();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bl_pwm_fader.md
BL_PWM_FADER -- requirements
Module: bl_pwm_fader

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent backlight/enable channels (1..8).
REQ-002 SHALL have parameter PERIOD, default 1000: PWM period in clk cycles; must be a multiple of MAX_LEVEL.
REQ-003 SHALL have parameter FADE_DIV, default 4: PWM periods per one-level fade step (1..255).
REQ-004 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts every pwm_out bit.
REQ-005 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-006 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port wr_valid  input  1: write strobe for one channel's target level.
REQ-008 SHALL have port wr_ch  input  3: channel index for the write.
REQ-009 SHALL have port wr_level  input  8: requested level, 0..MAX_LEVEL in percent.
REQ-010 SHALL have port fade_en  input  1: 1 = ramp to target, 0 = jump to target.
REQ-011 SHALL have port pwm_out  output  NUM_CH: registered PWM outputs.
REQ-012 SHALL have port settled  output  NUM_CH: current level equals target, per channel.
REQ-013 SHALL have port period_tick  output  1: one-cycle pulse on the last cycle of every period.

Function
REQ-014 SHALL run one shared period counter 0..PERIOD-1, incrementing every cycle and wrapping to 0; period_tick high when counter = PERIOD-1.
REQ-015 SHALL, on wr_valid with wr_ch < NUM_CH, load target[wr_ch] with min(wr_level, MAX_LEVEL) next cycle; writes with wr_ch >= NUM_CH are ignored.
REQ-016 SHALL always accept writes (no back-pressure); the last write before an update wins.
REQ-017 SHALL update current level cur[i] only on period_tick cycles.
REQ-018 SHALL, with fade_en=0, set cur[i] = target[i] at the next period_tick.
REQ-019 SHALL, with fade_en=1, move cur[i] by exactly 1 toward target[i] at every FADE_DIV-th period_tick (shared fade divider); no change when equal.
REQ-020 SHALL, when a write and period_tick coincide, use the old target for that update; the new target applies from the following period_tick.
REQ-021 SHALL latch threshold thr[i] = cur[i] * (PERIOD/MAX_LEVEL) at the same period boundary, so duty never changes mid-period (glitch-free).
REQ-022 SHALL drive pwm_out[i] (before ACTIVE_LOW inversion) = 1 when counter < thr[i], registered, one cycle latency from counter.
REQ-023 SHALL give level 0 a constant inactive output and level MAX_LEVEL a constant active output with no single-cycle glitches.
REQ-024 SHALL drive settled[i] = (cur[i] == target[i]), registered.
REQ-025 SHALL size internal arithmetic to clog2(PERIOD+1) bits with no overflow for any legal parameter set.

Reset
REQ-026 SHALL, on reset_n low, asynchronously clear counter, fade divider, target, cur and thr to 0.
REQ-027 SHALL reset pwm_out to the inactive level (0, or all-ones when ACTIVE_LOW=1), settled to all-ones, period_tick to 0.
REQ-028 SHALL, on reset assertion mid-fade or mid-period, abandon all state; after release the first period starts at counter 0.

Structure
REQ-029 SHALL place MAX_LEVEL (100), default PERIOD and default FADE_DIV in shared package bl_pkg.
REQ-030 SHALL instantiate sub-module bl_fade_channel once per channel (target, cur, thr, compare, settled); counter and fade divider live in the top.

Verification
REQ-031 Reset, write ch0 level 50, fade_en=0 -> after next period_tick pwm_out[0] high exactly 500 of every 1000 cycles.
REQ-032 fade_en=1, FADE_DIV=4, ch1 0 -> 10 -> cur steps 1 per 4 periods, settled[1] rises after 40 periods, duty reaches 100/1000.
REQ-033 Write level 200 to ch2 -> clamped to 100, pwm_out[2] constantly high, no low cycle.
REQ-034 Write ch3 level 30 on the period_tick cycle -> duty unchanged that period, 300/1000 from the following period; write wr_ch=7 with NUM_CH=4 -> no state change.
REQ-035 ACTIVE_LOW=1, level 0 -> pwm_out constant 1; reset_n pulsed low mid-fade -> outputs inactive immediately, settled all-ones, counter restarts at 0.
